// File: rtl/dac_player_pkg.sv
// Shared types and constants for the BRAM-to-DAC playback engine.
// Latency: n/a (package). Backpressure: n/a.
// Holds the playback state encoding, lane geometry and Q1.15 saturation helper.
package dac_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LANE_W = 16;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  function automatic int lane_count(input int data_w);
    return data_w / LANE_W;
  endfunction

  // Clamp a 17-bit post-shift product back into the Q1.15 range.
  function automatic logic [15:0] sat_q15(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return SAT_MAX;
    end else if (v < -17'sd32768) begin
      return SAT_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/dac_lane_gain.sv
// One DAC lane scaled by a signed Q1.15 gain, arithmetic shift by 15, saturated.
// Latency: combinational; the instantiating stage provides the register.
// Backpressure: none, pure datapath.
module dac_lane_gain
  import dac_player_pkg::*;
(
  input  logic [15:0] sample,
  input  logic [15:0] gain,
  output logic [15:0] scaled
);

  logic signed [31:0] prod;
  logic signed [16:0] shifted;

  assign prod    = $signed(sample) * $signed(gain);
  assign shifted = 17'(prod >>> 15);
  assign scaled  = sat_q15(shifted);

endmodule

// File: rtl/bram_dac_player.sv
// Streams BRAM words 0..length onto the DAC lane, one-shot or looping; optional gain via DAC_PLAYER_GAIN_EN.
// Latency: start to first dac word RDLAT+1 clocks (+1 with DAC_PLAYER_GAIN_EN).
// Backpressure: none; one word per clock, stop drains in-flight reads before going idle.
module bram_dac_player
  import dac_player_pkg::*;
#(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 256,
  parameter int RDLAT     = 2
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic [ADDRWIDTH-1:0] length,
  input  logic [15:0]          gain,
  output logic [ADDRWIDTH-1:0] bram_addr,
  output logic                 bram_en,
  input  logic [DATAWIDTH-1:0] bram_data,
  output logic [DATAWIDTH-1:0] dac,
  output logic                 dac_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [RDLAT-1:0] TAIL_BIT = RDLAT'(1) << (RDLAT - 1);

  state_t                 state;
  logic [ADDRWIDTH-1:0]   len_r;
  logic [RDLAT-1:0]       rd_vld_sr;
  logic                   pipe_tail;
  logic                   pipe_rest_empty;
  logic                   mid_vld;
  logic                   drain_empty;
  logic                   last_word;

  assign pipe_tail       = rd_vld_sr[RDLAT-1];
  assign pipe_rest_empty = ((rd_vld_sr & ~TAIL_BIT) == '0);
  assign drain_empty     = (rd_vld_sr == '0) && !mid_vld;
  // Only a word leaving an otherwise empty pipe in DRAIN can be the run's last.
  assign last_word       = (state == DRAIN) && pipe_tail && pipe_rest_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_r     <= '0;
      bram_addr <= '0;
      bram_en   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= PLAY;
            len_r     <= length;
            bram_addr <= '0;
            bram_en   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PLAY: begin
          if (stop) begin
            state   <= DRAIN;
            bram_en <= 1'b0;
          end else if (bram_addr == len_r) begin
            if (loop) begin
              bram_addr <= '0;
            end else begin
              state   <= DRAIN;
              bram_en <= 1'b0;
            end
          end else begin
            bram_addr <= bram_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tracks which BRAM read slots carry a real word, aligned to bram_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_sr <= '0;
    end else begin
      rd_vld_sr[0] <= bram_en;
      for (int i = 1; i < RDLAT; i++) begin
        rd_vld_sr[i] <= rd_vld_sr[i-1];
      end
    end
  end

`ifdef DAC_PLAYER_GAIN_EN
  localparam int LANES = lane_count(DATAWIDTH);

  logic [DATAWIDTH-1:0] mid_dat;
  logic [DATAWIDTH-1:0] gained;
  logic                 mid_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mid_vld  <= 1'b0;
      mid_dat  <= '0;
      mid_done <= 1'b0;
    end else begin
      mid_vld  <= pipe_tail;
      mid_dat  <= pipe_tail ? bram_data : '0;
      mid_done <= last_word;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dac_lane_gain u_gain (
      .sample (mid_dat[g*LANE_W +: LANE_W]),
      .gain   (gain),
      .scaled (gained[g*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac       <= '0;
      dac_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      dac       <= mid_vld ? gained : '0;
      dac_valid <= mid_vld;
      done      <= mid_done;
    end
  end
`else
  logic gain_unused;

  assign mid_vld     = 1'b0;
  assign gain_unused = ^gain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac       <= '0;
      dac_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      dac       <= pipe_tail ? bram_data : '0;
      dac_valid <= pipe_tail;
      done      <= last_word;
    end
  end
`endif

endmodule

// File: tb/tb_bram_dac_player.sv
// Randomized and directed playback runs checked against a read-list model of the player.
module tb_bram_dac_player;

  localparam int ADDRWIDTH = 13;
  localparam int DATAWIDTH = 256;
  localparam int RDLAT     = 2;
`ifdef DAC_PLAYER_GAIN_EN
  localparam int LAT = RDLAT + 2;
`else
  localparam int LAT = RDLAT + 1;
`endif

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 stop;
  logic                 loop;
  logic [ADDRWIDTH-1:0] length;
  logic [15:0]          gain;
  logic [ADDRWIDTH-1:0] bram_addr;
  logic                 bram_en;
  logic [DATAWIDTH-1:0] bram_data;
  logic [DATAWIDTH-1:0] dac;
  logic                 dac_valid;
  logic                 busy;
  logic                 done;

  logic [DATAWIDTH-1:0] mem [0:(1<<ADDRWIDTH)-1];
  logic [DATAWIDTH-1:0] rd_p1;

  int checks = 0;
  int errors = 0;

  bram_dac_player #(
    .ADDRWIDTH (ADDRWIDTH),
    .DATAWIDTH (DATAWIDTH),
    .RDLAT     (RDLAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .length    (length),
    .gain      (gain),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_data (bram_data),
    .dac       (dac),
    .dac_valid (dac_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-clock BRAM: address registered by the DUT, then two internal stages.
  always @(posedge clk) begin
    rd_p1     <= mem[bram_addr];
    bram_data <= rd_p1;
  end

  task automatic chk(input string tag, input logic [DATAWIDTH-1:0] got,
                     input logic [DATAWIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DATAWIDTH-1:0] exp_word(input int a);
    logic [DATAWIDTH-1:0] w;
    w = mem[a];
`ifdef DAC_PLAYER_GAIN_EN
    for (int i = 0; i < DATAWIDTH/16; i++) begin
      logic signed [15:0] s;
      logic signed [15:0] gs;
      int p;
      s  = w[i*16 +: 16];
      gs = gain;
      p  = s * gs;
      p  = p >>> 15;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      w[i*16 +: 16] = p[15:0];
    end
`endif
    return w;
  endfunction

  // stop_at: edge index (relative to the start edge 0) where stop is sampled; -1 = never.
  // loop is held at lp for edges before loop_off, then 0.
  task automatic run_play(input int len, input bit lp, input int loop_off, input int stop_at);
    int addrs[$];
    int a;
    int j;
    int n;
    bit fin;
    logic [DATAWIDTH-1:0] ew;
    bit ev;
    a   = 0;
    j   = 0;
    fin = (stop_at == 0);
    while (!fin) begin
      addrs.push_back(a);
      if (stop_at == j + 1) begin
        fin = 1'b1;
      end else if (a == len) begin
        if (lp && (j + 1) < loop_off) a = 0;
        else fin = 1'b1;
      end else begin
        a = a + 1;
      end
      j++;
    end
    n = addrs.size();

    for (int k = 0; k < n + LAT + 3; k++) begin
      @(negedge clk);
      start  = (k == 0);
      stop   = (k == stop_at);
      loop   = lp && (k < loop_off);
      length = (k == 0) ? ADDRWIDTH'(len) : ADDRWIDTH'($urandom);
      @(posedge clk);
      #1;
      ev = (k >= LAT) && (k < LAT + n);
      ew = ev ? exp_word(addrs[k-LAT]) : '0;
      chk($sformatf("bram_en k=%0d", k), bram_en, (k < n));
      if (k < n) chk($sformatf("bram_addr k=%0d", k), bram_addr, addrs[k]);
      chk($sformatf("busy k=%0d", k), busy, (n > 0) && (k < LAT + n));
      chk($sformatf("dac_valid k=%0d", k), dac_valid, ev);
      chk($sformatf("dac k=%0d", k), dac, ew);
      chk($sformatf("done k=%0d", k), done, (n > 0) && (k == LAT + n - 1));
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    loop   = 1'b0;
    length = '0;
    gain   = 16'h4000;
    for (int a = 0; a < (1 << ADDRWIDTH); a++) begin
      for (int i = 0; i < DATAWIDTH/16; i++) begin
        mem[a][i*16 +: 16] = (a < 8) ? 16'(a) : 16'($urandom);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst dac", dac, '0);
    chk("rst dac_valid", dac_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst bram_en", bram_en, 1'b0);
    chk("rst bram_addr", bram_addr, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // One-shot, loop across a short length, early stop, simultaneous start+stop.
    run_play(3, 1'b0, 0, -1);
    run_play(1, 1'b1, 10, -1);
    run_play(100, 1'b0, 0, 2);
    run_play(5, 1'b0, 0, 0);
    run_play(0, 1'b1, 6, -1);
    run_play(0, 1'b0, 0, -1);
    run_play(4, 1'b1, 30, 7);

    // Reset during the 4th word of a length-7 run.
    @(negedge clk);
    start  = 1'b1;
    length = 7;
    for (int k = 0; k <= LAT + 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("pre-rst dac_valid", dac_valid, 1'b1);
    chk("pre-rst dac", dac, exp_word(3));
    reset = 1'b1;
    #1;
    chk("midrst dac", dac, '0);
    chk("midrst dac_valid", dac_valid, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst bram_en", bram_en, 1'b0);
    chk("midrst done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_play(7, 1'b0, 0, -1);

`ifdef DAC_PLAYER_GAIN_EN
    for (int i = 0; i < DATAWIDTH/16; i++) begin
      mem[0][i*16 +: 16] = i[0] ? 16'h8000 : 16'h7FFF;
    end
    gain = 16'h4000;
    run_play(0, 1'b0, 0, -1);
    gain = 16'h8000;
    run_play(0, 1'b0, 0, -1);
`endif

    for (int r = 0; r < 12; r++) begin
      gain = 16'($urandom);
      run_play($urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom_range(1, 40),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
